alu_op_sequencer: RTL and testbench

//  Button-driven initiator for the lab ALU: owns the ALU operand/op/mode inputs and captures its outputs.

---
 rtl/alu_op_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Button-driven initiator for the lab ALU. It debounces two active-low push
//   buttons, steps an op index with one and starts an operation with the other.
//   On execute it latches the switch operands and mode into the ALU inputs,
//   holds them for a settle window, then captures the ALU result and carries
//   for the display stage.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   sw_a_i, sw_b_i   operand switches (N bits)
//   sw_mode_i        {sum_en, sub_en} switches, latched on execute
//   btn_next_n_i     step op index, active low
//   btn_exec_n_i     execute current op, active low
//   alu_result_i     ALU primary result (N bits)
//   alu_mult_i       ALU multiply result (2N bits)
//   alu_csum_i       ALU carry of sum
//   alu_csub_i       ALU carry/borrow of subtract
//   alu_a_o, alu_b_o operands driven to the ALU
//   alu_op_o         op lines to the ALU, active low (~op index)
//   alu_sum_o        sum enable to the ALU
//   alu_sub_o        subtract enable to the ALU
//   op_idx_o         current op index for display
//   result_o         captured result (2N bits)
//   csum_o, csub_o   captured carries
//   busy_o           high from LOAD through CAPTURE
//   done_o           one-cycle pulse in CAPTURE
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int MULT_IDX        = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   sw_a_i,
  input  logic [N-1:0]   sw_b_i,
  input  logic [1:0]     sw_mode_i,
  input  logic           btn_next_n_i,
  input  logic           btn_exec_n_i,
  input  logic [N-1:0]   alu_result_i,
  input  logic [2*N-1:0] alu_mult_i,
  input  logic           alu_csum_i,
  input  logic           alu_csub_i,
  output logic [N-1:0]   alu_a_o,
  output logic [N-1:0]   alu_b_o,
  output logic [2:0]     alu_op_o,
  output logic           alu_sum_o,
  output logic           alu_sub_o,
  output logic [2:0]     op_idx_o,
  output logic [2*N-1:0] result_o,
  output logic           csum_o,
  output logic           csub_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]      MULT_OP = 3'(MULT_IDX);

  localparam int BTN_NEXT = 0;
  localparam int BTN_EXEC = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            next_sync_q, exec_sync_q;
  logic [1:0]            btn_lvl;
  logic [1:0]            btn_evt;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  logic [2:0]            op_idx_q, op_idx_d;
  logic [ST_W-1:0]       settle_q, settle_d;
  logic                  load_en, cap_en;

  logic [N-1:0]          alu_a_q, alu_b_q;
  logic                  alu_sum_q, alu_sub_q;
  logic [2*N-1:0]        result_q;
  logic                  csum_q, csub_q;

  // Synchronisers reset to "released" so a reset never produces a press.
  assign btn_lvl[BTN_NEXT] = next_sync_q[1];
  assign btn_lvl[BTN_EXEC] = exec_sync_q[1];

  // Debounce: count consecutive low samples; the event fires on the sample
  // that completes the run. The counter then saturates so a held button gives
  // one event only, and any high sample re-arms it.
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_evt  = '0;
    for (int i = 0; i < 2; i++) begin
      if (btn_lvl[i]) begin
        db_cnt_d[i] = '0;
      end else begin
        if (db_cnt_q[i] == DB_LAST) btn_evt[i] = 1'b1;
        if (db_cnt_q[i] != DB_MAX)  db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Sequencer FSM: events are only honoured in IDLE, exec has priority.
  always_comb begin
    state_d  = state_q;
    op_idx_d = op_idx_q;
    settle_d = settle_q;
    load_en  = 1'b0;
    cap_en   = 1'b0;
    busy_o   = 1'b1;
    done_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o   = 1'b0;
        settle_d = '0;
        if (btn_evt[BTN_EXEC]) begin
          state_d = S_LOAD;
        end else if (btn_evt[BTN_NEXT]) begin
          op_idx_d = op_idx_q + 3'd1;
        end
      end
      S_LOAD: begin
        load_en  = 1'b1;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == ST_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        cap_en  = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      next_sync_q <= 2'b11;
      exec_sync_q <= 2'b11;
      db_cnt_q    <= '0;
      op_idx_q    <= 3'd0;
      settle_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sum_q   <= 1'b0;
      alu_sub_q   <= 1'b0;
      result_q    <= '0;
      csum_q      <= 1'b0;
      csub_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_sync_q <= {next_sync_q[0], btn_next_n_i};
      exec_sync_q <= {exec_sync_q[0], btn_exec_n_i};
      db_cnt_q    <= db_cnt_d;
      op_idx_q    <= op_idx_d;
      settle_q    <= settle_d;
      // Both enables are passed through as set on the switches; the ALU
      // decides what sum+sub together means.
      if (load_en) begin
        alu_a_q   <= sw_a_i;
        alu_b_q   <= sw_b_i;
        alu_sum_q <= sw_mode_i[1];
        alu_sub_q <= sw_mode_i[0];
      end
      if (cap_en) begin
        result_q <= (op_idx_q == MULT_OP) ? alu_mult_i : {{N{1'b0}}, alu_result_i};
        csum_q   <= alu_csum_i;
        csub_q   <= alu_csub_i;
      end
    end
  end

  assign alu_a_o   = alu_a_q;
  assign alu_b_o   = alu_b_q;
  assign alu_sum_o = alu_sum_q;
  assign alu_sub_o = alu_sub_q;
  assign alu_op_o  = ~op_idx_q;
  assign op_idx_o  = op_idx_q;
  assign result_o  = result_q;
  assign csum_o    = csum_q;
  assign csub_o    = csub_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   sw_a_i, sw_b_i;
  logic [1:0]     sw_mode_i;
  logic           btn_next_n_i, btn_exec_n_i;
  logic [N-1:0]   alu_result_i;
  logic [2*N-1:0] alu_mult_i;
  logic           alu_csum_i, alu_csub_i;
  logic [N-1:0]   alu_a_o, alu_b_o;
  logic [2:0]     alu_op_o;
  logic           alu_sum_o, alu_sub_o;
  logic [2:0]     op_idx_o;
  logic [2*N-1:0] result_o;
  logic           csum_o, csub_o, busy_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(
    .N(4), .DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2), .MULT_IDX(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sw_a_i(sw_a_i), .sw_b_i(sw_b_i), .sw_mode_i(sw_mode_i),
    .btn_next_n_i(btn_next_n_i), .btn_exec_n_i(btn_exec_n_i),
    .alu_result_i(alu_result_i), .alu_mult_i(alu_mult_i),
    .alu_csum_i(alu_csum_i), .alu_csub_i(alu_csub_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_sum_o(alu_sum_o), .alu_sub_o(alu_sub_o), .op_idx_o(op_idx_o),
    .result_o(result_o), .csum_o(csum_o), .csub_o(csub_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean press: low long enough to debounce, then released long enough to re-arm.
  task automatic press_next();
    btn_next_n_i = 1'b0;
    repeat (6) tick();
    btn_next_n_i = 1'b1;
    repeat (4) tick();
  endtask

  // Press exec and observe 14 cycles. Cycle c is sampled on the falling edge
  // after the c-th rising edge following the press. With a 2-FF synchroniser
  // and 4-sample debounce the exec event lands in cycle 5, so busy rises in
  // cycle 6 and done pulses in cycle 9. next_at: -1 none, 0 together with exec,
  // >0 next pressed at that cycle.
  task automatic run_exec(input int next_at, output int busy_first, output int done_at,
                          output int busy_cnt, output int done_cnt);
    busy_first = 0; done_at = 0; busy_cnt = 0; done_cnt = 0;
    tick();
    btn_exec_n_i = 1'b0;
    if (next_at == 0) btn_next_n_i = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy_o === 1'b1) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = c;
      end
      if (done_o === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c == next_at) btn_next_n_i = 1'b0;
      if (c == 6) btn_exec_n_i = 1'b1;
      if (c == 12) btn_next_n_i = 1'b1;
    end
  endtask

  task automatic test_reset();
    int stray;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({alu_a_o, alu_b_o, alu_sum_o, alu_sub_o} !== 10'd0) begin
      n_fail++; $display("FAIL reset_alu_inputs: got %h expected 0", {alu_a_o, alu_b_o, alu_sum_o, alu_sub_o});
    end
    n_checks++;
    if (alu_op_o !== 3'b111) begin
      n_fail++; $display("FAIL reset_alu_op: got %b expected 111", alu_op_o);
    end
    n_checks++;
    if (op_idx_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_op_idx: got %0d expected 0", op_idx_o);
    end
    n_checks++;
    if ({result_o, csum_o, csub_o} !== 10'd0) begin
      n_fail++; $display("FAIL reset_capture: got %h expected 0", {result_o, csum_o, csub_o});
    end
    n_checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_status: got %b expected 00", {busy_o, done_o});
    end
    rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || done_o !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0 || op_idx_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_idle: stray=%0d op_idx=%0d expected 0/0", stray, op_idx_o);
    end
  endtask

  task automatic test_bounce();
    tick();
    btn_next_n_i = 1'b0; repeat (3) tick();
    btn_next_n_i = 1'b1; repeat (1) tick();
    btn_next_n_i = 1'b0; repeat (10) tick();
    btn_next_n_i = 1'b1; repeat (4) tick();
    @(negedge clk);
    n_checks++;
    if (op_idx_o !== 3'd1) begin
      n_fail++; $display("FAIL bounce_op_idx: got %0d expected 1", op_idx_o);
    end
    n_checks++;
    if (alu_op_o !== 3'b110) begin
      n_fail++; $display("FAIL bounce_alu_op: got %b expected 110", alu_op_o);
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    repeat (7) press_next();
    @(negedge clk);
    n_checks++;
    if (op_idx_o !== 3'd7 || alu_op_o !== 3'b000) begin
      n_fail++; $display("FAIL wrap_seven: got idx %0d op %b expected 7/000", op_idx_o, alu_op_o);
    end
    press_next();
    @(negedge clk);
    n_checks++;
    if (op_idx_o !== 3'd0 || alu_op_o !== 3'b111) begin
      n_fail++; $display("FAIL wrap_zero: got idx %0d op %b expected 0/111", op_idx_o, alu_op_o);
    end
  endtask

  task automatic test_exec();
    int bf, da, bc, dc;
    sw_a_i = 4'b1111; sw_b_i = 4'b1000; sw_mode_i = 2'b10;
    alu_result_i = 4'b0111; alu_mult_i = 8'hAA; alu_csum_i = 1'b1; alu_csub_i = 1'b0;
    run_exec(-1, bf, da, bc, dc);
    n_checks++;
    if (bf != 6 || da != 9) begin
      n_fail++; $display("FAIL exec_latency: busy@%0d done@%0d expected busy@6 done@9", bf, da);
    end
    n_checks++;
    if (bc != 4 || dc != 1) begin
      n_fail++; $display("FAIL exec_pulses: busy %0d cyc done %0d expected 4/1", bc, dc);
    end
    n_checks++;
    if (result_o !== 8'h07) begin
      n_fail++; $display("FAIL exec_result: got %h expected 07", result_o);
    end
    n_checks++;
    if ({csum_o, csub_o} !== 2'b10) begin
      n_fail++; $display("FAIL exec_carries: got %b expected 10", {csum_o, csub_o});
    end
    n_checks++;
    if ({alu_a_o, alu_b_o, alu_sum_o, alu_sub_o} !== {4'hF, 4'h8, 2'b10}) begin
      n_fail++; $display("FAIL exec_operands: got %h expected %h", {alu_a_o, alu_b_o, alu_sum_o, alu_sub_o}, {4'hF, 4'h8, 2'b10});
    end
    n_checks++;
    if (op_idx_o !== 3'd0) begin
      n_fail++; $display("FAIL exec_op_idx: got %0d expected 0", op_idx_o);
    end
  endtask

  task automatic test_multiply();
    int bf, da, bc, dc;
    tick();
    repeat (3) press_next();
    @(negedge clk);
    n_checks++;
    if (op_idx_o !== 3'd3 || alu_op_o !== 3'b100) begin
      n_fail++; $display("FAIL mult_select: got idx %0d op %b expected 3/100", op_idx_o, alu_op_o);
    end
    sw_a_i = 4'b1001; sw_b_i = 4'b1001; sw_mode_i = 2'b11;
    alu_result_i = 4'h2; alu_mult_i = 8'h51; alu_csum_i = 1'b0; alu_csub_i = 1'b1;
    run_exec(-1, bf, da, bc, dc);
    n_checks++;
    if (result_o !== 8'h51 || dc != 1) begin
      n_fail++; $display("FAIL mult_result: got %h done %0d expected 51/1", result_o, dc);
    end
    n_checks++;
    if ({csum_o, csub_o, alu_sum_o, alu_sub_o} !== 4'b0111) begin
      n_fail++; $display("FAIL mult_flags: got %b expected 0111", {csum_o, csub_o, alu_sum_o, alu_sub_o});
    end
    n_checks++;
    if ({alu_a_o, alu_b_o} !== 8'h99) begin
      n_fail++; $display("FAIL mult_operands: got %h expected 99", {alu_a_o, alu_b_o});
    end
  endtask

  task automatic test_contention();
    int bf, da, bc, dc;
    int dones;
    alu_result_i = 4'h5; alu_mult_i = 8'h3C;
    run_exec(0, bf, da, bc, dc);
    n_checks++;
    if (op_idx_o !== 3'd3 || dc != 1 || result_o !== 8'h3C) begin
      n_fail++; $display("FAIL same_cycle: got idx %0d done %0d result %h expected 3/1/3c", op_idx_o, dc, result_o);
    end
    alu_mult_i = 8'hC3;
    run_exec(2, bf, da, bc, dc);
    repeat (10) tick();
    @(negedge clk);
    n_checks++;
    if (op_idx_o !== 3'd3 || dc != 1 || result_o !== 8'hC3) begin
      n_fail++; $display("FAIL next_in_settle: got idx %0d done %0d result %h expected 3/1/c3", op_idx_o, dc, result_o);
    end
    // Reset asserted during SETTLE.
    alu_mult_i = 8'hEE;
    tick();
    btn_exec_n_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL settle_reached: got busy %b done %b expected 1/0", busy_o, done_o);
    end
    rst_n = 1'b0;
    btn_exec_n_i = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, done_o, result_o, csum_o, csub_o} !== 12'd0) begin
      n_fail++; $display("FAIL abort_capture: got %h expected 0", {busy_o, done_o, result_o, csum_o, csub_o});
    end
    n_checks++;
    if ({op_idx_o, alu_op_o, alu_a_o, alu_b_o, alu_sum_o, alu_sub_o} !== {3'd0, 3'b111, 10'd0}) begin
      n_fail++; $display("FAIL abort_outputs: got %h expected %h", {op_idx_o, alu_op_o, alu_a_o, alu_b_o, alu_sum_o, alu_sub_o}, {3'd0, 3'b111, 10'd0});
    end
    dones = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) dones++;
      if (c == 2) rst_n = 1'b1;
    end
    n_checks++;
    if (dones != 0 || result_o !== 8'h00) begin
      n_fail++; $display("FAIL abort_no_done: got done %0d result %h expected 0/00", dones, result_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_next_n_i = 1'b1; btn_exec_n_i = 1'b1;
    sw_a_i = '0; sw_b_i = '0; sw_mode_i = '0;
    alu_result_i = '0; alu_mult_i = '0; alu_csum_i = 1'b0; alu_csub_i = 1'b0;
    test_reset();
    test_bounce();
    test_wrap();
    test_exec();
    test_multiply();
    test_contention();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
